ks_memory: RTL and testbench
============================

# ks_memory

Unified 32 x 16-bit program/data memory for the K&S processor, the responder on the RAM interface the data path drives (address, write data, write strobe, read data). After reset it zero-fills its array, accepts a program image over a valid/ready loader stream, then releases the processor and serves its reads and writes. It sits between the top-level loader (testbench or boot source) and the processor core.

## Interface

Parameters:
- DATA_W, 16, word width; must match the data path bus width.
- ADDR_W, 5, address width; the array depth is 2**ADDR_W = 32 words.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst_n  in  1  Reset. Synchronous, active-low.
- ram_addr  in  ADDR_W  Processor word address.
- ram_write_enable  in  1  Processor write strobe; honoured only in RUN.
- data_out  in  DATA_W  Processor write data.
- data_in  out  DATA_W  Read data to the processor: combinational, mem[ram_addr].
- load_valid  in  1  Loader word valid.
- load_data  in  DATA_W  Loader word.
- load_last  in  1  Marks the final loader word; qualified by load_valid.
- load_ready  out  1  High only in LOAD.
- reload  in  1  In RUN, restarts the CLEAR → LOAD sequence.
- cpu_run  out  1  High only in RUN; the top level gates the processor's rst_n with it.
- loaded_words  out  ADDR_W+1  Number of words accepted in the last load (0..32).

## Operation

- The state machine has three states: CLEAR, LOAD, RUN.
- While rst_n is low at an edge: state←CLEAR, clr_ptr←0, wr_ptr←0, loaded_words←0.
- Reset values of the outputs: load_ready=0, cpu_run=0, loaded_words=0. data_in is undefined until the first CLEAR pass completes.
- **CLEAR:** at each edge, mem[clr_ptr]←0 and clr_ptr←clr_ptr+1. On the edge that writes address 31, go to LOAD and set wr_ptr←0. Processor writes and loader words are ignored.
- **LOAD:** on each edge with load_valid=1, the word is accepted.
  - Effect of an accepted word: mem[wr_ptr]←load_data, wr_ptr+1, loaded_words+1.
  - Go to RUN if the accepted word had load_last=1, or if wr_ptr was 31 (a full image). A 32nd word always ends the load, whether or not load_last is set.
  - Unloaded addresses keep their CLEAR value of 0.
  - load_last without load_valid has no effect. ram_write_enable is ignored.
- **RUN:** at an edge with ram_write_enable=1, mem[ram_addr]←data_out (full word).
  - reload=1 at an edge: go to CLEAR with clr_ptr←0 and loaded_words←0. reload has priority, so a simultaneous processor write is discarded.
  - reload is ignored outside RUN.
- data_in = mem[ram_addr] in every state. There is no write-through bypass: after a write edge, data_in shows the new value.
- Pointer wrap: clr_ptr and wr_ptr never pass 31; the state changes on that edge.
- Reset mid-LOAD or mid-RUN: on the next edge the block is in CLEAR. Partial images are discarded by the zero-fill.

## Timing

- The CLEAR pass takes exactly 32 edges after the first edge with rst_n=1. load_ready rises in the cycle after the 32nd edge.
- Load throughput: one word per cycle when load_valid is held high. A full image takes 32 cycles.
- cpu_run rises in the cycle after the final word is accepted. Its minimum delay from the reset release edge is 33 cycles (32 CLEAR edges plus one single-word load).
- Read latency is 0 cycles (combinational from ram_addr). Write latency is 1 edge.
- The outputs load_ready, cpu_run and loaded_words are registered state decodes and change only at clock edges.
- reload to cpu_run low: 1 edge. The full sequence then repeats: 32 CLEAR edges, then LOAD.

## Test plan

- Reset held for 3 cycles, then released; load_valid=0 -> load_ready=0 for 32 cycles and =1 from cycle 33; cpu_run=0; data_in=0 for all 32 addresses.
- Load 4 words 16'h8101, 16'hA112, 16'h8223, 16'hFFFF (last on the 4th), with load_valid held high -> cpu_run=1 the cycle after the 4th accept; loaded_words=4; mem[0..3] match the image; mem[4..31]=0.
- Load 32 words i+16'h1000 with load_last never set -> RUN after the 32nd accept; loaded_words=32; a 33rd load_valid pulse is not accepted (load_ready=0).
- In RUN: ram_addr=5, data_out=16'hBEEF, ram_write_enable=1 for one edge -> data_in=16'hBEEF at addr 5. In the same cycle, ram_write_enable=1 with reload=1 at addr 6 -> mem[6] is not written; CLEAR restarts, and after 32 edges mem[5]=0.
- Reset asserted for 1 edge in the middle of a load (after 10 words) -> CLEAR the next cycle; loaded_words=0; after the re-clear, a 2-word load gives loaded_words=2 and mem[2..31]=0.
- Load stream with gaps (load_valid toggling 1,0,0,1,1 with last on the 3rd valid) -> exactly 3 words are written at addresses 0..2; cpu_run rises the cycle after the 3rd accept.

Source files
------------

// File: rtl/ks_memory.sv
// Unified program/data memory for the K&S processor: zero-fills after reset,
// accepts a program image over a valid/ready stream, then serves the core.
module ks_memory #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_write_enable,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic              cpu_run,
  output logic [ADDR_W:0]   loaded_words
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     loaded_q, loaded_d;
  logic                load_ready_q, load_ready_d;
  logic                cpu_run_q, cpu_run_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    loaded_d  = loaded_q;
    mem_we    = 1'b0;
    mem_waddr = ram_addr;
    mem_wdata = data_out;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_q;
          mem_wdata = load_data;
          wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
          loaded_d  = loaded_q + (ADDR_W+1)'(1);
          // A full image ends the load even without load_last.
          if (load_last || (wr_ptr_q == LAST_ADDR)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // reload wins over a simultaneous processor write.
        if (reload) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          loaded_d  = '0;
        end else if (ram_write_enable) begin
          mem_we = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    load_ready_d = (state_d == ST_LOAD);
    cpu_run_d    = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      wr_ptr_q     <= '0;
      loaded_q     <= '0;
      load_ready_q <= 1'b0;
      cpu_run_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      loaded_q     <= loaded_d;
      load_ready_q <= load_ready_d;
      cpu_run_q    <= cpu_run_d;
    end
  end

  // Writes are suppressed during reset; the following CLEAR pass wipes the array anyway.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign data_in      = mem_q[ram_addr];
  assign load_ready   = load_ready_q;
  assign cpu_run      = cpu_run_q;
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_ks_memory.sv
// Bench for ks_memory: table vectors, directed corner sequences and random
// traffic compared against a word-array reference model.
module tb_ks_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ram_addr;
  logic        ram_write_enable;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        reload;
  logic        cpu_run;
  logic [5:0]  loaded_words;

  ks_memory #(.DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr),
    .ram_write_enable(ram_write_enable), .data_out(data_out), .data_in(data_in),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .reload(reload), .cpu_run(cpu_run),
    .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  localparam int P_CLR = 0, P_LOAD = 1, P_RUN = 2;

  int          vectors = 0;
  int          miscompares = 0;
  int          phase = P_CLR;
  int          clr_cnt = 0;
  int          lcnt = 0;
  logic [15:0] m [32];
  bit          kn [32];

  typedef struct {
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        exp_ready;
    logic        exp_run;
    logic [5:0]  exp_loaded;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: memory is a plain array; phase advances by counting words.
  task automatic model_edge();
    if (!rst_n) begin
      phase = P_CLR; clr_cnt = 0; lcnt = 0;
    end else if (phase == P_CLR) begin
      m[clr_cnt] = 16'h0; kn[clr_cnt] = 1'b1;
      clr_cnt++;
      if (clr_cnt == 32) phase = P_LOAD;
    end else if (phase == P_LOAD) begin
      if (load_valid) begin
        m[lcnt] = load_data; kn[lcnt] = 1'b1;
        lcnt++;
        if (load_last || lcnt == 32) phase = P_RUN;
      end
    end else begin
      if (reload) begin
        phase = P_CLR; clr_cnt = 0; lcnt = 0;
      end else if (ram_write_enable) begin
        m[ram_addr] = data_out; kn[ram_addr] = 1'b1;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_load_ready", load_ready, phase == P_LOAD);
    chk("model_cpu_run", cpu_run, phase == P_RUN);
    chk("model_loaded_words", loaded_words, lcnt);
    if (kn[ram_addr]) chk("model_data_in", data_in, m[ram_addr]);
  endtask

  task automatic idle();
    rst_n = 1'b1; ram_write_enable = 1'b0; data_out = 16'h0; ram_addr = 5'd0;
    load_valid = 1'b0; load_data = 16'h0; load_last = 1'b0; reload = 1'b0;
  endtask

  task automatic read_chk(input string name, input int a, input logic [15:0] exp);
    ram_addr = 5'(a);
    #1;
    chk(name, data_in, exp);
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h8101, 1'b0, 1'b1, 1'b0, 6'd1};
    tbl[1] = '{1'b1, 16'hA112, 1'b0, 1'b1, 1'b0, 6'd2};
    tbl[2] = '{1'b1, 16'h8223, 1'b0, 1'b1, 1'b0, 6'd3};
    tbl[3] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 6'd4};
    for (int i = 0; i < 32; i++) kn[i] = 1'b0;

    // Reset for 3 cycles, then the clear pass
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_loaded_words", loaded_words, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("clear_load_ready", load_ready, (k == 32) ? 1 : 0);
      chk("clear_cpu_run", cpu_run, 0);
    end
    for (int a = 0; a < 32; a++) read_chk("clear_zero", a, 16'h0);

    // Table-driven 4-word load
    for (int i = 0; i < 4; i++) begin
      load_valid = tbl[i].valid; load_data = tbl[i].data; load_last = tbl[i].last;
      step();
      chk("tbl_load_ready", load_ready, tbl[i].exp_ready);
      chk("tbl_cpu_run", cpu_run, tbl[i].exp_run);
      chk("tbl_loaded_words", loaded_words, tbl[i].exp_loaded);
    end
    idle();
    for (int a = 0; a < 32; a++) read_chk("img4_mem", a, (a < 4) ? tbl[a].data : 16'h0);

    // Reload, then a full 32-word image without load_last
    reload = 1'b1;
    step();
    chk("reload_cpu_run_low", cpu_run, 0);
    reload = 1'b0;
    repeat (32) step();
    chk("reclear_load_ready", load_ready, 1);
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1; load_data = 16'(i) + 16'h1000; load_last = 1'b0;
      step();
      if (i < 31) chk("full_not_run_yet", cpu_run, 0);
    end
    chk("full_cpu_run", cpu_run, 1);
    chk("full_loaded_words", loaded_words, 32);
    load_data = 16'hDEAD;
    step();
    chk("extra_load_ready", load_ready, 0);
    chk("extra_loaded_words", loaded_words, 32);
    idle();
    for (int a = 0; a < 32; a++) read_chk("full_mem", a, 16'(a) + 16'h1000);

    // Processor write, then write colliding with reload
    ram_addr = 5'd5; data_out = 16'hBEEF; ram_write_enable = 1'b1;
    step();
    ram_write_enable = 1'b0;
    chk("run_write_beef", data_in, 16'hBEEF);
    ram_addr = 5'd6; data_out = 16'h1234; ram_write_enable = 1'b1; reload = 1'b1;
    step();
    ram_write_enable = 1'b0; reload = 1'b0;
    chk("collide_cpu_run", cpu_run, 0);
    chk("collide_no_write", data_in, 16'h1006);
    repeat (32) step();
    read_chk("reclear_addr5", 5, 16'h0);
    read_chk("reclear_addr6", 6, 16'h0);

    // Reset in the middle of a load
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_data = 16'($urandom); load_last = 1'b0;
      step();
    end
    chk("midload_loaded10", loaded_words, 10);
    rst_n = 1'b0;
    step();
    chk("midrst_load_ready", load_ready, 0);
    chk("midrst_loaded_words", loaded_words, 0);
    idle();
    repeat (32) step();
    load_valid = 1'b1; load_data = 16'h0A0A;
    step();
    load_data = 16'h0B0B; load_last = 1'b1;
    step();
    idle();
    chk("two_loaded_words", loaded_words, 2);
    chk("two_cpu_run", cpu_run, 1);
    read_chk("two_mem0", 0, 16'h0A0A);
    read_chk("two_mem1", 1, 16'h0B0B);
    for (int a = 2; a < 32; a++) read_chk("two_mem_zero", a, 16'h0);

    // Gapped load stream: valid 1,0,0,1,1 with last on the third valid word
    reload = 1'b1;
    step();
    reload = 1'b0;
    repeat (32) step();
    for (int i = 0; i < 5; i++) begin
      load_valid = (i == 0 || i >= 3);
      load_data  = 16'h3000 + 16'(i);
      load_last  = (i == 4);
      step();
      chk("gap_cpu_run", cpu_run, (i == 4) ? 1 : 0);
    end
    idle();
    chk("gap_loaded_words", loaded_words, 3);
    read_chk("gap_mem0", 0, 16'h3000);
    read_chk("gap_mem1", 1, 16'h3003);
    read_chk("gap_mem2", 2, 16'h3004);
    read_chk("gap_mem3", 3, 16'h0);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      rst_n            = ($urandom_range(0, 299) != 0);
      reload           = ($urandom_range(0, 59) == 0);
      ram_write_enable = $urandom_range(0, 1) == 1;
      ram_addr         = 5'($urandom);
      data_out         = 16'($urandom);
      load_valid       = $urandom_range(0, 2) != 0;
      load_data        = 16'($urandom);
      load_last        = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
